// File: rtl/iteration_calc.sv
// iteration_calc: Julia-set escape-time engine, one z <- z^2 + c step per clock.
//   All complex values are signed Q16.16 (re, im as separate 32-bit words).
//
// Ports
//   CLK, RESET           clock; synchronous active-high reset
//   start                one-cycle request, only looked at while idle
//   z_real_in/z_imag_in  starting point z0
//   c_real/c_imag        Julia constant c
//   busy                 high while iterating
//   done                 one-cycle pulse; results valid from this cycle on
//   escaped              z left the escape region before MAX_ITER steps
//   iter_count           iterations executed
//   intensity            n+1 for an escape at 0-based step n, else 0
//   z_real_out/z_imag_out last computed z
//
// Build option
//   ITER_ESCAPE_MAGSQ_EN  escape on |z|^2 > 4.0 instead of |re|+|im| > ESCAPE_L1
module iteration_calc #(
  parameter int          MAX_ITER  = 100,
  parameter logic [31:0] ESCAPE_L1 = 32'h0005_0000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        start,
  input  logic [31:0] z_real_in,
  input  logic [31:0] z_imag_in,
  input  logic [31:0] c_real,
  input  logic [31:0] c_imag,
  output logic        busy,
  output logic        done,
  output logic        escaped,
  output logic [7:0]  iter_count,
  output logic [7:0]  intensity,
  output logic [31:0] z_real_out,
  output logic [31:0] z_imag_out
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [7:0] LAST_N   = 8'(MAX_ITER - 1);
  localparam logic [7:0] MAX_CNT  = 8'(MAX_ITER);

  logic [1:0]  r_state;
  logic [31:0] r_zr, r_zi, r_cr, r_ci;
  logic [7:0]  r_n;

  // Full-width signed products of the current z.
  logic signed [63:0] w_zr_x, w_zi_x, w_p_rr, w_p_ii, w_p_ri;
  logic [31:0]        w_zr_nx, w_zi_nx;
  logic               w_esc;

  assign w_zr_x = {{32{r_zr[31]}}, r_zr};
  assign w_zi_x = {{32{r_zi[31]}}, r_zi};
  assign w_p_rr = w_zr_x * w_zr_x;
  assign w_p_ii = w_zi_x * w_zi_x;
  assign w_p_ri = w_zr_x * w_zi_x;

  // Arithmetic shift then keep the low word: floor-truncated Q16.16.
  // The shift by 15 on re*im gives the doubled cross term for free.
  assign w_zr_nx = 32'(w_p_rr >>> 16) - 32'(w_p_ii >>> 16) + r_cr;
  assign w_zi_nx = 32'(w_p_ri >>> 15) + r_ci;

`ifdef ITER_ESCAPE_MAGSQ_EN
  // Squares of the new z (exactly what the next iteration would form).
  logic signed [63:0] w_nr_x, w_ni_x, w_q_rr, w_q_ii;
  logic [32:0]        w_mag;
  logic [31:0]        w_sq_r, w_sq_i;

  assign w_nr_x = {{32{w_zr_nx[31]}}, w_zr_nx};
  assign w_ni_x = {{32{w_zi_nx[31]}}, w_zi_nx};
  assign w_q_rr = w_nr_x * w_nr_x;
  assign w_q_ii = w_ni_x * w_ni_x;
  assign w_sq_r = 32'(w_q_rr >>> 16);
  assign w_sq_i = 32'(w_q_ii >>> 16);
  assign w_mag  = {w_sq_r[31], w_sq_r} + {w_sq_i[31], w_sq_i};
  // A negative sum can only come from overflow of a huge z: treat as escape.
  assign w_esc  = w_mag[32] || ($signed(w_mag) > 33'sh0_0004_0000);
`else
  logic [32:0] w_abs_r, w_abs_i, w_l1;

  // Negating in 33 bits makes abs(0x8000_0000) come out as +2^31.
  assign w_abs_r = w_zr_nx[31] ? (33'd0 - {1'b1, w_zr_nx}) : {1'b0, w_zr_nx};
  assign w_abs_i = w_zi_nx[31] ? (33'd0 - {1'b1, w_zi_nx}) : {1'b0, w_zi_nx};
  assign w_l1    = w_abs_r + w_abs_i;
  assign w_esc   = w_l1 > {1'b0, ESCAPE_L1};
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state    <= IDLE;
      r_zr       <= '0;
      r_zi       <= '0;
      r_cr       <= '0;
      r_ci       <= '0;
      r_n        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      escaped    <= 1'b0;
      iter_count <= '0;
      intensity  <= '0;
      z_real_out <= '0;
      z_imag_out <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_zr       <= z_real_in;
            r_zi       <= z_imag_in;
            r_cr       <= c_real;
            r_ci       <= c_imag;
            r_n        <= '0;
            busy       <= 1'b1;
            escaped    <= 1'b0;
            iter_count <= '0;
            intensity  <= '0;
            z_real_out <= '0;
            z_imag_out <= '0;
            r_state    <= RUN;
          end
        end
        RUN: begin
          r_zr <= w_zr_nx;
          r_zi <= w_zi_nx;
          if (w_esc || r_n == LAST_N) begin
            busy       <= 1'b0;
            done       <= 1'b1;
            escaped    <= w_esc;
            iter_count <= w_esc ? r_n + 8'd1 : MAX_CNT;
            intensity  <= w_esc ? r_n + 8'd1 : 8'd0;
            z_real_out <= w_zr_nx;
            z_imag_out <= w_zi_nx;
            r_state    <= DONE;
          end else begin
            r_n <= r_n + 8'd1;
          end
        end
        DONE: begin
          done    <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iteration_calc.sv
module tb_iteration_calc;
  logic        CLK = 1'b0;
  logic        RESET, start;
  logic [31:0] z_real_in, z_imag_in, c_real, c_imag;
  logic        busy, done, escaped;
  logic [7:0]  iter_count, intensity;
  logic [31:0] z_real_out, z_imag_out;

  int checks = 0;
  int failures = 0;

  iteration_calc dut (
    .CLK(CLK), .RESET(RESET), .start(start),
    .z_real_in(z_real_in), .z_imag_in(z_imag_in),
    .c_real(c_real), .c_imag(c_imag),
    .busy(busy), .done(done), .escaped(escaped),
    .iter_count(iter_count), .intensity(intensity),
    .z_real_out(z_real_out), .z_imag_out(z_imag_out)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] zr, zi, cr, ci;
    logic        esc;
    logic [7:0]  cnt, inten;
    logic [31:0] ozr, ozi;
  } vec_t;

  vec_t vecs[7];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  // Waits (bounded) for done; returns edges seen after the start edge.
  task automatic wait_done(output int edges, output logic busy_ok);
    edges = 0;
    busy_ok = 1'b1;
    while (!done && edges < 400) begin
      if (!busy) busy_ok = 1'b0;
      tick();
      edges++;
    end
  endtask

  task automatic launch(input logic [31:0] zr, zi, cr, ci);
    z_real_in = zr; z_imag_in = zi; c_real = cr; c_imag = ci;
    start = 1'b1;
    tick();
    start = 1'b0;
    // Changing inputs after the start edge must not matter.
    z_real_in = 32'hDEAD_BEEF; z_imag_in = 32'h1234_5678;
    c_real = 32'h7FFF_0000; c_imag = 32'h8000_0000;
  endtask

  task automatic check_result(input string tag, input vec_t v, input int edges);
    chk({tag, ".done"},    {31'd0, done}, 32'd1);
    chk({tag, ".latency"}, edges, {24'd0, v.cnt});
    chk({tag, ".busy"},    {31'd0, busy}, 32'd0);
    chk({tag, ".esc"},     {31'd0, escaped}, {31'd0, v.esc});
    chk({tag, ".cnt"},     {24'd0, iter_count}, {24'd0, v.cnt});
    chk({tag, ".int"},     {24'd0, intensity}, {24'd0, v.inten});
    chk({tag, ".zr"},      z_real_out, v.ozr);
    chk({tag, ".zi"},      z_imag_out, v.ozi);
  endtask

  initial begin
    int   edges;
    logic bok;
    string tag;

    //          zr            zi            cr            ci            esc   cnt     int     ozr           ozi
    vecs[0] = '{32'h0,        32'h0,        32'h0,        32'h0,        1'b0, 8'd100, 8'd0,   32'h0,        32'h0};
    vecs[3] = '{32'h0,        32'h0,        32'hFFFF_0000,32'h0,        1'b0, 8'd100, 8'd0,   32'h0,        32'h0};
    vecs[5] = '{32'h0,        32'h0,        32'h0003_0000,32'h0003_0000,1'b1, 8'd1,   8'd1,   32'h0003_0000,32'h0003_0000};
`ifdef ITER_ESCAPE_MAGSQ_EN
    vecs[1] = '{32'h0002_0000,32'h0,        32'h0,        32'h0,        1'b1, 8'd1,   8'd1,   32'h0004_0000,32'h0};
    vecs[2] = '{32'h0001_0000,32'h0001_0000,32'h0,        32'h0,        1'b1, 8'd2,   8'd2,   32'hFFFC_0000,32'h0};
    vecs[4] = '{32'h0001_8000,32'h0001_8000,32'h0,        32'h0,        1'b1, 8'd1,   8'd1,   32'h0,        32'h0004_8000};
    vecs[6] = '{32'h0,        32'h0,        32'h0005_0000,32'h0,        1'b1, 8'd1,   8'd1,   32'h0005_0000,32'h0};
`else
    vecs[1] = '{32'h0002_0000,32'h0,        32'h0,        32'h0,        1'b1, 8'd2,   8'd2,   32'h0010_0000,32'h0};
    vecs[2] = '{32'h0001_0000,32'h0001_0000,32'h0,        32'h0,        1'b1, 8'd3,   8'd3,   32'h0010_0000,32'h0};
    vecs[4] = '{32'h0001_8000,32'h0001_8000,32'h0,        32'h0,        1'b1, 8'd2,   8'd2,   32'hFFEB_C000,32'h0};
    // |z1| = 5.0 exactly is not an escape; z2 = 30.0 is.
    vecs[6] = '{32'h0,        32'h0,        32'h0005_0000,32'h0,        1'b1, 8'd2,   8'd2,   32'h001E_0000,32'h0};
`endif

    RESET = 1'b1; start = 1'b0;
    z_real_in = '0; z_imag_in = '0; c_real = '0; c_imag = '0;
    tick(); tick();
    RESET = 1'b0;
    chk("rst.busy", {31'd0, busy}, 32'd0);
    chk("rst.done", {31'd0, done}, 32'd0);
    chk("rst.cnt",  {24'd0, iter_count}, 32'd0);
    chk("rst.zr",   z_real_out, 32'd0);

    for (int i = 0; i < 7; i++) begin
      tag = $sformatf("v%0d", i);
      launch(vecs[i].zr, vecs[i].zi, vecs[i].cr, vecs[i].ci);
      chk({tag, ".busy1"}, {31'd0, busy}, 32'd1);
      wait_done(edges, bok);
      chk({tag, ".busyrun"}, {31'd0, bok}, 32'd1);
      check_result(tag, vecs[i], edges);
      tick();
      chk({tag, ".pulse"}, {31'd0, done}, 32'd0);
      chk({tag, ".hold"},  {24'd0, intensity}, {24'd0, vecs[i].inten});
    end

    // start while running is ignored (its z0=2.0 would escape quickly).
    launch(32'h0, 32'h0, 32'h0, 32'h0);
    repeat (10) tick();
    z_real_in = 32'h0002_0000; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(edges, bok);
    check_result("ignrun", vecs[0], edges + 11);

    // start during the DONE cycle is not queued.
    z_real_in = 32'h0002_0000; start = 1'b1;
    tick();
    start = 1'b0;
    chk("igndone.done", {31'd0, done}, 32'd0);
    tick(); tick();
    chk("igndone.busy", {31'd0, busy}, 32'd0);

    // Reset while results are held clears them.
    launch(vecs[5].zr, vecs[5].zi, vecs[5].cr, vecs[5].ci);
    wait_done(edges, bok);
    check_result("prerst", vecs[5], edges);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    chk("rstd.done", {31'd0, done}, 32'd0);
    chk("rstd.esc",  {31'd0, escaped}, 32'd0);
    chk("rstd.cnt",  {24'd0, iter_count}, 32'd0);
    chk("rstd.int",  {24'd0, intensity}, 32'd0);
    chk("rstd.zr",   z_real_out, 32'd0);
    chk("rstd.zi",   z_imag_out, 32'd0);

    // Reset mid-run aborts with no done pulse.
    launch(32'h0, 32'h0, 32'h0, 32'h0);
    repeat (5) tick();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    chk("rstm.busy", {31'd0, busy}, 32'd0);
    bok = 1'b1;
    for (int k = 0; k < 120; k++) begin
      if (done || busy) bok = 1'b0;
      tick();
    end
    chk("rstm.quiet", {31'd0, bok}, 32'd1);

    launch(vecs[1].zr, vecs[1].zi, vecs[1].cr, vecs[1].ci);
    wait_done(edges, bok);
    check_result("afterrst", vecs[1], edges);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/iteration_calc.md
Name: iteration_calc

Overview:
- Per-pixel Julia-set escape-time engine, instantiated inside fractal_calc.
- Takes a starting point z0 and a constant c, both signed Q16.16 complex values.
- Iterates z <- z^2 + c, one iteration per clock, until z escapes or MAX_ITER iterations complete.
- Reports iteration count, escape flag and an 8-bit intensity for the VGA path.

Parameters:
- MAX_ITER, 100, maximum iterations per pixel (1..255).
- ESCAPE_L1, 32'h0005_0000, escape threshold (5.0 in Q16.16) applied to |re|+|im|.

Ports:
- CLK  in  1  clock.
- RESET  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- z_real_in  in  32  signed Q16.16, real part of z0.
- z_imag_in  in  32  signed Q16.16, imaginary part of z0.
- c_real  in  32  signed Q16.16, real part of c.
- c_imag  in  32  signed Q16.16, imaginary part of c.
- busy  out  1  high while iterating.
- done  out  1  one-cycle pulse; results valid from this cycle on.
- escaped  out  1  1 = z escaped before MAX_ITER.
- iter_count  out  8  number of iterations executed.
- intensity  out  8  n+1 on escape at 0-based iteration n; 0 if no escape.
- z_real_out  out  32  final z, real part.
- z_imag_out  out  32  final z, imaginary part.

Behaviour:
- Reset: RESET is synchronous, active-high; clock is CLK. Reset forces state IDLE and clears every output (busy, done, escaped, iter_count, intensity, z_real_out, z_imag_out) to 0. Reset mid-run aborts the run with no done pulse.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - When start=1 at a rising edge: latch z0 and c into internal registers, set n=0, go to RUN, set busy=1.
  - Inputs may change after that edge without effect.
- RUN, each edge computes:
  - zr' = (zr*zr)[47:16] - (zi*zi)[47:16] + c_real
  - zi' = (zr*zi)[46:15] + c_imag, i.e. the doubled product
  - Products are full 64-bit signed. Slicing truncates (rounds toward -inf). Adds wrap mod 2^32; no saturation.
- Escape test on the new z:
  - Compute |zr'|+|zi'| as a 33-bit unsigned value; abs(0x8000_0000) = 2^31.
  - Escape when the sum is strictly greater than ESCAPE_L1.
- Escape at iteration n: go to DONE with escaped=1, iter_count=n+1, intensity=n+1.
- No escape and n==MAX_ITER-1: go to DONE with escaped=0, iter_count=MAX_ITER, intensity=0.
- Otherwise: n increments and the FSM stays in RUN.
- z_real_out/z_imag_out take the last computed z.
- DONE: lasts one cycle with done=1 and busy=0, then returns to IDLE. Results hold until the next start or reset.
- Latency: done is high in the cycle following the (n+1)-th edge after the edge that sampled start. A full non-escaping run gives done after MAX_ITER edges.
- start while busy or in DONE is ignored, not queued.
- intensity never exceeds MAX_ITER (100 by default).

Optional Feature:
- Macro ITER_ESCAPE_MAGSQ_EN.
- When defined, the escape test becomes zr'^2 + zi'^2 > 4.0:
  - Use the Q16.16 squares already computed for the next iteration.
  - Sum as 33-bit signed; compare > 32'h0004_0000; a negative result (overflow) also counts as escape.
  - ESCAPE_L1 is unused in this mode.
- When undefined, the L1 test above applies.
- Latency and all other behaviour are identical in both modes.

Test Plan:
- z0=(0,0), c=(0,0), start pulse -> busy for 100 cycles, done after 100 edges, escaped=0, iter_count=100, intensity=0, z_out=(0,0).
- z0=(2.0,0) (0x0002_0000), c=0 -> z1=4 (no escape, equals neither >5), z2=16 escapes; done after 2 edges, escaped=1, iter_count=2, intensity=2, z_real_out=0x0010_0000.
- z0=(1.0,1.0), c=0 -> z1=(0,2), z2=(-4,0), z3=(16,0); escaped=1, intensity=3, done after 3 edges.
- z0=(0,0), c=(-1.0,0) (0xFFFF_0000) -> 2-cycle orbit, no escape; iter_count=100, intensity=0, escaped=0.
- Start during RUN ignored; RESET asserted mid-run -> next cycle IDLE, all outputs 0, no done pulse; a new start then completes normally.
- With ITER_ESCAPE_MAGSQ_EN: z0=(1.5,1.5), c=0 -> z1=(0,4.5), mag^2=20.25 -> escape at n=0, intensity=1. Without the macro: L1=4.5, no escape; z2=(-20.25,0) escapes, intensity=2.
